// File: rtl/pio_color_arbiter_pkg.sv
// Shared definitions for the PIO color arbiter: CSR map, ctrl/edge bit
// positions and the arbiter FSM encoding.
package pio_color_arbiter_pkg;

    localparam logic [1:0] ADDR_COLOR = 2'd0;
    localparam logic [1:0] ADDR_CTRL  = 2'd1;
    localparam logic [1:0] ADDR_EDGE  = 2'd2;
    localparam logic [1:0] ADDR_MASK  = 2'd3;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_RR     = 1;

    localparam int EDGE_A = 0;
    localparam int EDGE_B = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_A = 2'd1,
        ST_LOAD_B = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

endpackage

// File: rtl/pio_color_hold_timer.sv
// Down-counter that keeps a granted color stable for HOLD_CYCLES cycles.
module pio_color_hold_timer #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic count,
    output logic done
);

    logic [7:0] cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= 8'(HOLD_CYCLES - 1);
        end else if (count && (cnt_reg != 8'd0)) begin
            cnt_reg <= cnt_reg - 8'd1;
        end
    end

    assign done = (cnt_reg == 8'd0);

endmodule

// File: rtl/pio_color_arbiter.sv
// Two-requester color arbiter feeding a PIO input port, with a small CSR
// block (ctrl, sticky load flags with write-1-to-clear, irq mask).
module pio_color_arbiter
    import pio_color_arbiter_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             ack_a,
    output logic             ack_b,
    output logic [WIDTH-1:0] color_out,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   color_reg;
    logic               enable_reg, rr_reg;
    logic [1:0]         edge_reg, mask_reg;
    src_t               last_reg;
    logic [31:0]        readdata_reg, readdata_next;
    logic               pick_a, pick_b, grant_a, grant_b;
    logic               timer_load, timer_count, timer_done;
    logic [1:0]         edge_set, edge_clr;
    logic               wdata_unused;

    assign wdata_unused = ^writedata[31:2];

    pio_color_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (timer_load),
        .count  (timer_count),
        .done   (timer_done)
    );

    always_comb begin
        state_next  = state_reg;
        pick_a      = 1'b0;
        pick_b      = 1'b0;
        timer_load  = 1'b0;
        timer_count = 1'b0;
        // On a tie, round-robin favours whoever was not served last.
        if (req_a && req_b) begin
            pick_a = rr_reg ? (last_reg == SRC_B) : 1'b1;
            pick_b = !pick_a;
        end else begin
            pick_a = req_a;
            pick_b = req_b;
        end
        case (state_reg)
            ST_IDLE: begin
                if (enable_reg && pick_a) begin
                    state_next = ST_LOAD_A;
                end else if (enable_reg && pick_b) begin
                    state_next = ST_LOAD_B;
                end
            end
            ST_LOAD_A, ST_LOAD_B: begin
                timer_load = 1'b1;
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                timer_count = 1'b1;
                if (timer_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Data is captured on the grant edge while req is still guaranteed high.
    assign grant_a = (state_reg == ST_IDLE) && (state_next == ST_LOAD_A);
    assign grant_b = (state_reg == ST_IDLE) && (state_next == ST_LOAD_B);

    assign edge_set = {grant_b, grant_a};
    assign edge_clr = (write && (address == ADDR_EDGE)) ? writedata[1:0] : 2'b00;

    always_comb begin
        readdata_next = 32'd0;
        case (address)
            ADDR_COLOR: readdata_next = 32'(color_reg);
            ADDR_CTRL:  readdata_next = {30'd0, rr_reg, enable_reg};
            ADDR_EDGE:  readdata_next = {30'd0, edge_reg};
            ADDR_MASK:  readdata_next = {30'd0, mask_reg};
            default:    readdata_next = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            color_reg    <= '0;
            enable_reg   <= 1'b0;
            rr_reg       <= 1'b0;
            edge_reg     <= 2'b00;
            mask_reg     <= 2'b00;
            last_reg     <= SRC_B;
            readdata_reg <= 32'd0;
        end else begin
            state_reg    <= state_next;
            readdata_reg <= readdata_next;
            if (grant_a) begin
                color_reg <= data_a;
                last_reg  <= SRC_A;
            end else if (grant_b) begin
                color_reg <= data_b;
                last_reg  <= SRC_B;
            end
            edge_reg <= (edge_reg & ~edge_clr) | edge_set;
            if (write && (address == ADDR_CTRL)) begin
                enable_reg <= writedata[CTRL_ENABLE];
                rr_reg     <= writedata[CTRL_RR];
            end
            if (write && (address == ADDR_MASK)) begin
                mask_reg <= writedata[1:0];
            end
        end
    end

    assign ack_a     = (state_reg == ST_LOAD_A);
    assign ack_b     = (state_reg == ST_LOAD_B);
    assign color_out = color_reg;
    assign readdata  = readdata_reg;
    assign irq       = |(edge_reg & mask_reg);

endmodule

// File: tb/tb_pio_color_arbiter.sv
// Randomized self-checking bench for pio_color_arbiter against a
// transaction-level model (grant spacing rule, sticky flags, CSR shadow).
module tb_pio_color_arbiter;

    localparam int W = 8;
    localparam int H = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_a = 1'b0, req_b = 1'b0;
    logic [W-1:0]  data_a = '0, data_b = '0;
    logic          ack_a, ack_b, irq;
    logic [W-1:0]  color_out;
    logic [1:0]    address = 2'd0;
    logic          write = 1'b0;
    logic [31:0]   writedata = 32'd0;
    logic [31:0]   readdata;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state
    logic          m_en, m_rr, m_last_b, m_ack_a, m_ack_b;
    logic [1:0]    m_edge, m_mask;
    logic [W-1:0]  m_color;
    logic [31:0]   m_rd;
    int            cyc = 0;
    int            m_next_ok = 0;

    pio_color_arbiter #(.WIDTH(W), .HOLD_CYCLES(H)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_a(req_a), .req_b(req_b), .data_a(data_a), .data_b(data_b),
        .ack_a(ack_a), .ack_b(ack_b), .color_out(color_out),
        .address(address), .write(write), .writedata(writedata),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_en = 0; m_rr = 0; m_last_b = 1; m_ack_a = 0; m_ack_b = 0;
        m_edge = 0; m_mask = 0; m_color = 0; m_rd = 0;
        m_next_ok = cyc;
    endtask

    // One clock edge of the model: a grant may occur only when enabled and at
    // least H+2 cycles have passed since the previous grant.
    task automatic model_edge();
        logic [31:0] rd;
        logic wa, wb;
        case (address)
            2'd0: rd = {24'd0, m_color};
            2'd1: rd = {30'd0, m_rr, m_en};
            2'd2: rd = {30'd0, m_edge};
            default: rd = {30'd0, m_mask};
        endcase
        wa = 0; wb = 0;
        if (m_en && (cyc >= m_next_ok) && (req_a || req_b)) begin
            if (req_a && req_b) wa = m_rr ? m_last_b : 1'b1;
            else wa = req_a;
            wb = !wa;
            m_next_ok = cyc + H + 2;
            m_last_b = wb;
            m_color = wa ? data_a : data_b;
        end
        m_ack_a = wa; m_ack_b = wb;
        if (write && address == 2'd1) begin m_en = writedata[0]; m_rr = writedata[1]; end
        if (write && address == 2'd2) m_edge = m_edge & ~writedata[1:0];
        if (write && address == 2'd3) m_mask = writedata[1:0];
        m_edge = m_edge | {wb, wa};
        m_rd = rd;
        cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 0; req_a = 0; req_b = 0; write = 0; address = 0; writedata = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset_n = 1;
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1;
        step();
        write = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (color_out !== 8'h00 || ack_a !== 1'b0 || ack_b !== 1'b0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: color=%h ack_a=%b ack_b=%b irq=%b required 00/0/0/0", color_out, ack_a, ack_b, irq);
        end
        for (int a = 0; a < 2; a++) begin
            address = 2'(a);
            step();
            n_cmp++;
            if (readdata !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_read addr=%0d: got %h required 00000000", a, readdata);
            end
        end
    endtask

    task automatic test_fixed_priority();
        int prev, nacks;
        do_reset();
        csr_write(2'd1, 32'd1);
        data_a = 8'h3C; data_b = 8'hA5; req_a = 1; req_b = 1;
        prev = -1; nacks = 0;
        for (int i = 0; i < 4 * (H + 2) + 2; i++) begin
            step();
            n_cmp++;
            if (ack_a !== m_ack_a || ack_b !== 1'b0) begin
                n_fail++;
                $display("FAIL fixed_ack cyc=%0d: ack_a=%b ack_b=%b required %b/0", i, ack_a, ack_b, m_ack_a);
            end
            if (ack_a) begin
                n_cmp++;
                if (color_out !== 8'h3C) begin
                    n_fail++;
                    $display("FAIL fixed_color: got %h required 3c", color_out);
                end
                if (prev >= 0) begin
                    n_cmp++;
                    if (i - prev !== H + 2) begin
                        n_fail++;
                        $display("FAIL fixed_spacing: got %0d required %0d", i - prev, H + 2);
                    end
                end
                prev = i; nacks++;
            end
        end
        n_cmp++;
        if (nacks < 3) begin
            n_fail++;
            $display("FAIL fixed_ack_count: got %0d required >=3", nacks);
        end
        req_a = 0; req_b = 0;
    endtask

    task automatic test_round_robin();
        logic [W-1:0] seen [3];
        logic [W-1:0] want [3];
        int n;
        want[0] = 8'h3C; want[1] = 8'hA5; want[2] = 8'h3C;
        do_reset();
        csr_write(2'd1, 32'd3);
        data_a = 8'h3C; data_b = 8'hA5; req_a = 1; req_b = 1;
        n = 0;
        for (int i = 0; i < 3 * (H + 2) + 4 && n < 3; i++) begin
            step();
            n_cmp++;
            if (ack_a !== m_ack_a || ack_b !== m_ack_b || color_out !== m_color) begin
                n_fail++;
                $display("FAIL rr_cycle %0d: ack=%b%b color=%h required %b%b %h", i, ack_a, ack_b, color_out, m_ack_a, m_ack_b, m_color);
            end
            if (ack_a || ack_b) begin seen[n] = color_out; n++; end
        end
        n_cmp++;
        if (n != 3) begin
            n_fail++;
            $display("FAIL rr_timeout: got %0d acks required 3", n);
        end
        for (int k = 0; k < n; k++) begin
            n_cmp++;
            if (seen[k] !== want[k]) begin
                n_fail++;
                $display("FAIL rr_sequence[%0d]: got %h required %h", k, seen[k], want[k]);
            end
        end
        req_a = 0; req_b = 0;
    endtask

    task automatic test_irq();
        bit got;
        do_reset();
        csr_write(2'd3, 32'd2);
        csr_write(2'd1, 32'd1);
        data_b = 8'h11; req_b = 1; got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (ack_b) got = 1;
        end
        req_b = 0;
        n_cmp++;
        if (!got || color_out !== 8'h11 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_set: ack_seen=%0d color=%h irq=%b required 1 11 1", got, color_out, irq);
        end
        csr_write(2'd2, 32'd2);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_clear: got %b required 0", irq);
        end
        repeat (H + 3) step();
        data_b = 8'h22; req_b = 1;
        csr_write(2'd2, 32'd2);
        req_b = 0;
        n_cmp++;
        if (ack_b !== 1'b1 || irq !== 1'b1 || irq !== m_edge[1]) begin
            n_fail++;
            $display("FAIL irq_set_wins: ack_b=%b irq=%b required 1 1", ack_b, irq);
        end
        address = 2'd2;
        step();
        n_cmp++;
        if (readdata !== 32'd2) begin
            n_fail++;
            $display("FAIL edge_read: got %h required 00000002", readdata);
        end
    endtask

    task automatic test_enable_mid_hold();
        bit got;
        int k;
        do_reset();
        csr_write(2'd1, 32'd1);
        data_a = 8'($urandom); req_a = 1; got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (ack_a) got = 1;
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL en_first_ack: no ack_a within 10 cycles");
        end
        csr_write(2'd1, 32'd0);
        for (int i = 0; i < 3 * (H + 2); i++) begin
            step();
            n_cmp++;
            if (ack_a !== 1'b0 || ack_a !== m_ack_a) begin
                n_fail++;
                $display("FAIL en_disabled_ack cyc=%0d: got %b required 0", i, ack_a);
            end
        end
        csr_write(2'd1, 32'd1);
        got = 0; k = 0;
        for (int i = 0; i < 2 && !got; i++) begin
            step();
            k++;
            if (ack_a) got = 1;
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL en_reenable_ack: none after %0d cycles, required within 2", k);
        end
        req_a = 0;
    endtask

    task automatic test_reset_in_load_b();
        bit got;
        do_reset();
        csr_write(2'd1, 32'd1);
        data_b = 8'($urandom_range(1, 255)); req_b = 1; got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (ack_b) got = 1;
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL rst_load_b_reach: no ack_b within 10 cycles");
        end
        reset_n = 0;
        #1;
        n_cmp++;
        if (color_out !== 8'h00 || ack_b !== 1'b0 || ack_a !== 1'b0 || readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_in_load: color=%h ack_b=%b ack_a=%b rd=%h required 00 0 0 0", color_out, ack_b, ack_a, readdata);
        end
        model_reset();
        #1 reset_n = 1;
        for (int i = 0; i < H + 3; i++) begin
            step();
            n_cmp++;
            if (ack_b !== 1'b0 || color_out !== 8'h00) begin
                n_fail++;
                $display("FAIL rst_after: ack_b=%b color=%h required 0 00", ack_b, color_out);
            end
        end
        req_b = 0;
    endtask

    task automatic test_soak();
        do_reset();
        csr_write(2'd1, 32'd1);
        for (int i = 0; i < 1500; i++) begin
            req_a = 1'($urandom); req_b = 1'($urandom);
            data_a = 8'($urandom); data_b = 8'($urandom);
            address = 2'($urandom);
            write = ($urandom_range(0, 7) == 0);
            writedata = $urandom;
            if (address == 2'd1) writedata[0] = ($urandom_range(0, 3) != 0);
            step();
            n_cmp++;
            if (ack_a !== m_ack_a || ack_b !== m_ack_b || color_out !== m_color ||
                readdata !== m_rd || irq !== |(m_edge & m_mask) || (ack_a && ack_b)) begin
                n_fail++;
                $display("FAIL soak cyc=%0d: ack=%b%b color=%h rd=%h irq=%b required %b%b %h %h %b",
                         i, ack_a, ack_b, color_out, readdata, irq,
                         m_ack_a, m_ack_b, m_color, m_rd, |(m_edge & m_mask));
            end
        end
        write = 0; req_a = 0; req_b = 0;
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_irq();
        test_enable_mid_hold();
        test_reset_in_load_b();
        test_soak();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
